// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / load-hazard unit.
//   FWD_RF / FWD_WB / FWD_MEM : operand-select encodings driven on fwd_a/fwd_b
//   DEF_ADDR_W                : default register-address width
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int DEF_ADDR_W = 5;

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Forwarding select for one EX operand.
//   rs                  : EX-stage source address
//   mem_regwrite/mem_rd : MEM-stage write enable and destination
//   wb_regwrite/wb_rd   : WB-stage write enable and destination
//   sel                 : FWD_MEM, FWD_WB or FWD_RF (never 2'b11)
module fwd_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic [1:0]        sel
);

  // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != {ADDR_W{1'b0}}) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != {ADDR_W{1'b0}}) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus a scoreboard for long-latency loads.
//   clk, rst_n                       : clock, synchronous active-low reset
//   ex_rs1/ex_rs2, mem_*/wb_*        : forwarding inputs -> fwd_a/fwd_b
//   id_valid, id_rs1/id_rs2          : ID instruction -> stall
//   ld_issue_valid/rd, ld_issue_ready: load-issue handshake
//   ld_done_valid/rd                 : load-return notification
//   outstanding                      : in-flight load count
//   stall_cnt                        : saturating count of stalled cycles
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            ex_rs1,
  input  logic [ADDR_W-1:0]            ex_rs2,
  input  logic                         mem_regwrite,
  input  logic                         wb_regwrite,
  input  logic [ADDR_W-1:0]            mem_rd,
  input  logic [ADDR_W-1:0]            wb_rd,
  input  logic                         id_valid,
  input  logic [ADDR_W-1:0]            id_rs1,
  input  logic [ADDR_W-1:0]            id_rs2,
  input  logic                         ld_issue_valid,
  input  logic [ADDR_W-1:0]            ld_issue_rd,
  output logic                         ld_issue_ready,
  input  logic                         ld_done_valid,
  input  logic [ADDR_W-1:0]            ld_done_rd,
  output logic [1:0]                   fwd_a,
  output logic [1:0]                   fwd_b,
  output logic                         stall,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  logic [NREG-1:0]  pending_r;
  logic [NREG-1:0]  pending_nxt_s;
  logic [OUT_W-1:0] outstanding_r;
  logic [OUT_W-1:0] outstanding_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             issue_acc_s;
  logic             done_acc_s;

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs(ex_rs1), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .sel(fwd_a)
  );

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs(ex_rs2), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .sel(fwd_b)
  );

  // Handshake, acceptance and stall are all derived from registered state only.
  always_comb begin
    ld_issue_ready = (outstanding_r < OUT_W'(MAX_OUT)) && !pending_r[ld_issue_rd];
    // An issue to x0 handshakes but is a no-op.
    issue_acc_s    = ld_issue_valid && ld_issue_ready && (ld_issue_rd != {ADDR_W{1'b0}});
    // Done for a non-pending register (spurious or pre-reset) is dropped.
    done_acc_s     = ld_done_valid && pending_r[ld_done_rd];
    stall          = id_valid && (pending_r[id_rs1] || pending_r[id_rs2]);
  end

  // Next scoreboard and count. Issue and done can never hit the same register in
  // one cycle: an issue needs the bit clear, a done needs it set.
  always_comb begin
    pending_nxt_s = pending_r;
    if (done_acc_s) begin
      pending_nxt_s[ld_done_rd] = 1'b0;
    end else begin
      pending_nxt_s[ld_done_rd] = pending_r[ld_done_rd];
    end
    if (issue_acc_s) begin
      pending_nxt_s[ld_issue_rd] = 1'b1;
    end else begin
      pending_nxt_s[ld_issue_rd] = pending_nxt_s[ld_issue_rd];
    end
    pending_nxt_s[0] = 1'b0;

    case ({issue_acc_s, done_acc_s})
      2'b10:   outstanding_nxt_s = outstanding_r + OUT_W'(1);
      2'b01:   outstanding_nxt_s = outstanding_r - OUT_W'(1);
      default: outstanding_nxt_s = outstanding_r;
    endcase
  end

  // State registers; reset drops all in-flight loads and clears the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r     <= {NREG{1'b0}};
      outstanding_r <= {OUT_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      pending_r     <= pending_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      if (stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign outstanding = outstanding_r;
  assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit (ADDR_W=5, MAX_OUT=4, CNT_W=4).
module tb_fwd_hazard_unit;

  localparam int ADDR_W  = 5;
  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 4;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);

  localparam int K_FWD_A = 0;
  localparam int K_FWD_B = 1;
  localparam int K_STALL = 2;
  localparam int K_READY = 3;
  localparam int K_OUT   = 4;
  localparam int K_CNT   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] ex_rs1, ex_rs2, mem_rd, wb_rd, id_rs1, id_rs2;
  logic [ADDR_W-1:0] ld_issue_rd, ld_done_rd;
  logic              mem_regwrite, wb_regwrite, id_valid;
  logic              ld_issue_valid, ld_issue_ready, ld_done_valid;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall;
  logic [OUT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fwd_hazard_unit #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_rd(mem_rd), .wb_rd(wb_rd),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_issue_ready(ld_issue_ready),
    .ld_done_valid(ld_done_valid), .ld_done_rd(ld_done_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall),
    .outstanding(outstanding), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_FWD_A: obs = {30'd0, fwd_a};
      K_FWD_B: obs = {30'd0, fwd_b};
      K_STALL: obs = {31'd0, stall};
      K_READY: obs = {31'd0, ld_issue_ready};
      K_OUT:   obs = 32'(outstanding);
      K_CNT:   obs = 32'(stall_cnt);
      default: obs = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs(e.kind);
      n_tests++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  // Advance one clock edge; inputs are then driven in the low phase.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    ld_issue_valid = 1'b0; ld_issue_rd = 5'd0;
    ld_done_valid = 1'b0; ld_done_rd = 5'd0;
    repeat (2) @(negedge clk);

    // Reset state
    id_valid = 1'b1; id_rs1 = 5'd3; id_rs2 = 5'd7; ld_issue_rd = 5'd5;
    expect_val("rst_stall", K_STALL, 32'd0);
    expect_val("rst_ready", K_READY, 32'd1);
    expect_val("rst_out",   K_OUT,   32'd0);
    expect_val("rst_cnt",   K_CNT,   32'd0);
    drain();
    id_valid = 1'b0;
    rst_n = 1'b1;

    // Forwarding priority
    mem_regwrite = 1'b1; mem_rd = 5'd5; wb_regwrite = 1'b1; wb_rd = 5'd5;
    ex_rs1 = 5'd5; ex_rs2 = 5'd5;
    expect_val("fwd_mem_a", K_FWD_A, 32'h2);
    expect_val("fwd_mem_b", K_FWD_B, 32'h2);
    drain();
    mem_regwrite = 1'b0;
    expect_val("fwd_wb_a", K_FWD_A, 32'h1);
    expect_val("fwd_wb_b", K_FWD_B, 32'h1);
    drain();
    mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    expect_val("fwd_x0_a", K_FWD_A, 32'h0);
    expect_val("fwd_x0_b", K_FWD_B, 32'h0);
    drain();
    mem_rd = 5'd6; wb_rd = 5'd5; ex_rs1 = 5'd5; ex_rs2 = 5'd6;
    expect_val("fwd_mix_a", K_FWD_A, 32'h1);
    expect_val("fwd_mix_b", K_FWD_B, 32'h2);
    drain();
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    expect_val("fwd_none_a", K_FWD_A, 32'h0);
    expect_val("fwd_none_b", K_FWD_B, 32'h0);
    drain();
    tick();

    // Load-use: issue rd=7 at cycle 0
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
    expect_val("lu_ready", K_READY, 32'd1);
    drain();
    tick();
    ld_issue_valid = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd7;
    expect_val("lu_c1_stall", K_STALL, 32'd1);
    expect_val("lu_c1_out",   K_OUT,   32'd1);
    expect_val("lu_c1_cnt",   K_CNT,   32'd0);
    drain();
    tick();
    expect_val("lu_c2_stall", K_STALL, 32'd1);
    expect_val("lu_c2_cnt",   K_CNT,   32'd1);
    drain();
    tick();
    ld_done_valid = 1'b1; ld_done_rd = 5'd7;
    expect_val("lu_c3_stall", K_STALL, 32'd1);
    expect_val("lu_c3_cnt",   K_CNT,   32'd2);
    drain();
    tick();
    ld_done_valid = 1'b0;
    expect_val("lu_c4_stall", K_STALL, 32'd0);
    expect_val("lu_c4_cnt",   K_CNT,   32'd3);
    expect_val("lu_c4_out",   K_OUT,   32'd0);
    drain();
    tick();
    id_valid = 1'b0;
    expect_val("lu_cnt_hold", K_CNT, 32'd3);
    drain();

    // Full: issue rd=1..4
    for (int r = 1; r <= 4; r++) begin
      ld_issue_valid = 1'b1; ld_issue_rd = 5'(r);
      expect_val("full_fill_ready", K_READY, 32'd1);
      drain();
      tick();
    end
    ld_issue_rd = 5'd5;
    expect_val("full_out",   K_OUT,   32'd4);
    expect_val("full_ready", K_READY, 32'd0);
    drain();
    tick();
    ld_issue_valid = 1'b0; ld_done_valid = 1'b1; ld_done_rd = 5'd2;
    expect_val("full_not_taken", K_OUT,   32'd4);
    expect_val("full_still_0",   K_READY, 32'd0);
    drain();
    tick();
    ld_done_valid = 1'b0;
    expect_val("full_ready_back", K_READY, 32'd1);
    expect_val("full_out_3",      K_OUT,   32'd3);
    drain();

    // Simultaneous issue rd=9 with done rd=3 (pending: 1,3,4)
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd9; ld_done_valid = 1'b1; ld_done_rd = 5'd3;
    expect_val("sim_ready", K_READY, 32'd1);
    drain();
    tick();
    ld_done_valid = 1'b0;
    expect_val("sim_out",      K_OUT,   32'd3);
    expect_val("waw_ready_0",  K_READY, 32'd0);
    drain();
    id_valid = 1'b1; id_rs1 = 5'd9; id_rs2 = 5'd0;
    expect_val("sim_p9_set", K_STALL, 32'd1);
    drain();
    id_rs1 = 5'd3;
    expect_val("sim_p3_clr", K_STALL, 32'd0);
    drain();
    tick();
    id_valid = 1'b0; ld_issue_valid = 1'b0;
    expect_val("waw_out", K_OUT, 32'd3);
    expect_val("sim_cnt", K_CNT, 32'd3);
    drain();

    // Spurious done rd=12 and issue rd=0
    ld_done_valid = 1'b1; ld_done_rd = 5'd12;
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
    expect_val("x0_ready", K_READY, 32'd1);
    drain();
    tick();
    ld_done_valid = 1'b0; ld_issue_valid = 1'b0; ld_issue_rd = 5'd12;
    expect_val("spur_out",      K_OUT,   32'd3);
    expect_val("spur_ready_12", K_READY, 32'd1);
    drain();
    ld_issue_rd = 5'd1;
    expect_val("spur_p1_kept", K_READY, 32'd0);
    drain();
    id_valid = 1'b1; id_rs1 = 5'd12; id_rs2 = 5'd0;
    expect_val("spur_no_stall", K_STALL, 32'd0);
    drain();
    id_rs1 = 5'd4;
    expect_val("spur_p4_kept", K_STALL, 32'd1);
    drain();

    // Reset mid-operation with 3 loads outstanding and a stall active
    rst_n = 1'b0; ld_issue_valid = 1'b1; ld_issue_rd = 5'd20;
    tick();
    rst_n = 1'b1; ld_issue_valid = 1'b0; id_rs1 = 5'd9;
    expect_val("mrst_out",   K_OUT,   32'd0);
    expect_val("mrst_cnt",   K_CNT,   32'd0);
    expect_val("mrst_stall", K_STALL, 32'd0);
    ld_issue_rd = 5'd20;
    expect_val("mrst_ready", K_READY, 32'd1);
    drain();
    id_valid = 1'b0; ld_done_valid = 1'b1; ld_done_rd = 5'd9;
    tick();
    ld_done_valid = 1'b0;
    expect_val("mrst_no_underflow", K_OUT, 32'd0);
    drain();

    // Saturation: stall for 20 cycles with CNT_W=4
    ld_issue_valid = 1'b1; ld_issue_rd = 5'd10;
    tick();
    ld_issue_valid = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd10; id_rs2 = 5'd0;
    repeat (5) tick();
    expect_val("sat_cnt_5", K_CNT, 32'd5);
    drain();
    repeat (15) tick();
    expect_val("sat_cnt_15", K_CNT,   32'd15);
    expect_val("sat_stall",  K_STALL, 32'd1);
    drain();
    ld_done_valid = 1'b1; ld_done_rd = 5'd10;
    tick();
    ld_done_valid = 1'b0;
    expect_val("sat_release", K_STALL, 32'd0);
    expect_val("sat_hold",    K_CNT,   32'd15);
    drain();
    id_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
